wifi_rx_deser_fifo: RTL and testbench



---
 rtl/wifi_rx_deser_fifo_if.sv | 29 ++
 rtl/wifi_rx_deser_fifo.sv | 157 +++++++++++++++
 tb/tb_wifi_rx_deser_fifo.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wifi_rx_deser_fifo_if.sv
// Bus bundle between the RX decoder / AHB register side and wifi_rx_deser_fifo.
// master drives bits, flush, pops and interrupt control; slave returns the FIFO head and status.
interface wifi_rx_deser_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    logic                       bit_valid;
    logic                       bit_in;
    logic                       flush;
    logic                       soft_clear;
    logic                       rd_en;
    logic [DATA_WIDTH-1:0]      data_out;
    logic                       valid_out;
    logic [$clog2(DEPTH):0]     level;
    logic                       en_rx_irq;
    logic                       clear_rx_irq;
    logic                       rx_irq;
    logic                       overflow;

    modport master (
        output bit_valid, bit_in, flush, soft_clear, rd_en, en_rx_irq, clear_rx_irq,
        input  data_out, valid_out, level, rx_irq, overflow
    );

    modport slave (
        input  bit_valid, bit_in, flush, soft_clear, rd_en, en_rx_irq, clear_rx_irq,
        output data_out, valid_out, level, rx_irq, overflow
    );
endinterface

// File: rtl/wifi_rx_deser_fifo.sv
// Bit-serial to word deserializer feeding a FWFT FIFO with sticky threshold interrupt and overflow.
// Optional macro WIFI_RX_DESER_MSB_FIRST_EN: first bit of a word lands in the MSB instead of the LSB.
module wifi_rx_deser_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int IRQ_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    wifi_rx_deser_fifo_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

`ifdef WIFI_RX_DESER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] THR_LVL  = LW'(IRQ_THRESH);

    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_next;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         bit_pos;
    logic                  asm_push;

    logic                  stg_valid;
    logic [DATA_WIDTH-1:0] stg_data;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_inc;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pop;
    logic                  push_ok;
    logic                  irq_q;
    logic                  irq_set;
    logic                  ovf_q;
    logic                  en_q;

    // Assembly: merge the incoming bit, then decide whether this cycle closes a word.
    always_comb begin
        bit_pos   = MSB_FIRST ? (LAST_BIT - bit_cnt) : bit_cnt;
        word_next = word_q;
        if (bus.bit_valid) begin
            word_next[bit_pos] = bus.bit_in;
        end
        asm_push = (bus.bit_valid && (bit_cnt == LAST_BIT)) ||
                   (bus.flush && ((bit_cnt != '0) || bus.bit_valid));
    end

    // A completed word sits one cycle in the staging register before entering the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q    <= '0;
            bit_cnt   <= '0;
            stg_valid <= 1'b0;
            stg_data  <= '0;
        end else if (bus.soft_clear) begin
            word_q    <= '0;
            bit_cnt   <= '0;
            stg_valid <= 1'b0;
            stg_data  <= '0;
        end else begin
            stg_valid <= asm_push;
            stg_data  <= word_next;
            if (asm_push) begin
                word_q  <= '0;
                bit_cnt <= '0;
            end else if (bus.bit_valid) begin
                word_q  <= word_next;
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        pop        = bus.rd_en && (level_q != '0);
        push_ok    = stg_valid && ((level_q != FULL_LVL) || pop);
        level_next = level_q + LW'(push_ok) - LW'(pop);
        rd_ptr_inc = rd_ptr + PW'(1);
        // Rising crossing of the threshold, or enable rising while already at/above it.
        irq_set    = bus.en_rx_irq &&
                     (((level_q < THR_LVL) && (level_next >= THR_LVL)) ||
                      (!en_q && (level_q >= THR_LVL)));
    end

    always_ff @(posedge clk) begin
        if (push_ok && !bus.soft_clear) begin
            mem[wr_ptr] <= stg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            data_q  <= '0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            en_q <= bus.en_rx_irq;
            if (bus.soft_clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
                data_q  <= '0;
                irq_q   <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                level_q <= level_next;
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr_inc;
                end
                if (stg_valid && !push_ok) begin
                    ovf_q <= 1'b1;
                end
                if (irq_set) begin
                    irq_q <= 1'b1;
                end else if (bus.clear_rx_irq) begin
                    irq_q <= 1'b0;
                end
                // Head register: bypass the staged word when it becomes the new head.
                if (pop) begin
                    if (level_q == LW'(1)) begin
                        if (push_ok) begin
                            data_q <= stg_data;
                        end
                    end else begin
                        data_q <= mem[rd_ptr_inc];
                    end
                end else if (push_ok && (level_q == '0)) begin
                    data_q <= stg_data;
                end
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = (level_q != '0);
    assign bus.level     = level_q;
    assign bus.rx_irq    = irq_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_wifi_rx_deser_fifo.sv
// Bench for wifi_rx_deser_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_wifi_rx_deser_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int THR   = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

`ifdef WIFI_RX_DESER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wifi_rx_deser_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    wifi_rx_deser_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IRQ_THRESH(THR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit en_lvl   = 1'b0;

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] part_w;
    int            part_n;
    bit            infl;
    logic [DW-1:0] infl_w;
    bit            m_irq;
    bit            m_ovf;
    bit            m_en_prev;

    task automatic model_reset();
        exp_q.delete();
        part_w    = '0;
        part_n    = 0;
        infl      = 1'b0;
        infl_w    = '0;
        m_irq     = 1'b0;
        m_ovf     = 1'b0;
        m_en_prev = 1'b0;
    endtask

    task automatic model_step(input bit bv, input bit bi, input bit fl, input bit sc,
                              input bit rd, input bit en, input bit clr);
        int lvl;
        int nlvl;
        bit set;
        if (sc) begin
            model_reset();
            m_en_prev = en;
            return;
        end
        lvl = exp_q.size();
        if (rd && lvl > 0) void'(exp_q.pop_front());
        if (infl) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(infl_w);
            else m_ovf = 1'b1;
        end
        nlvl = exp_q.size();
        set = en && ((lvl < THR && nlvl >= THR) || (!m_en_prev && lvl >= THR));
        if (set) m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;
        m_en_prev = en;
        infl = 1'b0;
        if (bv) begin
            if (MSB_FIRST) part_w[DW-1-part_n] = bi;
            else part_w[part_n] = bi;
            part_n++;
        end
        if (part_n == DW || (fl && part_n > 0)) begin
            infl   = 1'b1;
            infl_w = part_w;
            part_w = '0;
            part_n = 0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("level", 32'(bus.level), 32'(exp_q.size()));
        check_eq("valid_out", 32'(bus.valid_out), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check_eq("data_out", bus.data_out, exp_q[0]);
        check_eq("rx_irq", 32'(bus.rx_irq), 32'(m_irq));
        check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; applies inputs for one cycle and checks after the next fall.
    task automatic step(input bit bv, input bit bi, input bit fl, input bit sc,
                        input bit rd, input bit en, input bit clr);
        bus.bit_valid    = bv;
        bus.bit_in       = bi;
        bus.flush        = fl;
        bus.soft_clear   = sc;
        bus.rd_en        = rd;
        bus.en_rx_irq    = en;
        bus.clear_rx_irq = clr;
        @(posedge clk);
        model_step(bv, bi, fl, sc, rd, en, clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, en_lvl, 0);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++)
            step(1, MSB_FIRST ? w[DW-1-i] : w[i], 0, 0, 0, en_lvl, 0);
    endtask

    task automatic do_clear();
        step(0, 0, 0, 1, 0, en_lvl, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] words [9];
        logic [DW-1:0] w;
        bit            fl_bits [5];
        logic [31:0]   flush_exp;

        reset            = 1'b0;
        bus.bit_valid    = 1'b0;
        bus.bit_in       = 1'b0;
        bus.flush        = 1'b0;
        bus.soft_clear   = 1'b0;
        bus.rd_en        = 1'b0;
        bus.en_rx_irq    = 1'b0;
        bus.clear_rx_irq = 1'b0;
        model_reset();
        #1;
        check_eq("rst_data_out", bus.data_out, 32'h0);
        check_eq("rst_valid_out", 32'(bus.valid_out), 32'h0);
        check_eq("rst_level", 32'(bus.level), 32'h0);
        check_eq("rst_rx_irq", 32'(bus.rx_irq), 32'h0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Packing
        send_word(32'hA5A5_0F0F);
        idle(1);
        check_eq("pack_data", bus.data_out, 32'hA5A5_0F0F);
        check_eq("pack_level", 32'(bus.level), 32'd1);

        // Flush of a 5-bit partial word
        do_clear();
        fl_bits = '{1, 0, 1, 1, 0};
        for (int i = 0; i < 5; i++) step(1, fl_bits[i], 0, 0, 0, en_lvl, 0);
        step(0, 0, 1, 0, 0, en_lvl, 0);
        idle(1);
        flush_exp = MSB_FIRST ? 32'hB000_0000 : 32'h0000_000D;
        check_eq("flush_data", bus.data_out, flush_exp);
        step(0, 0, 1, 0, 0, en_lvl, 0);
        idle(1);
        check_eq("flush_noop_level", 32'(bus.level), 32'd1);
        // Bit plus flush in the same cycle, including the word-completing bit
        step(1, 1, 1, 0, 0, en_lvl, 0);
        for (int i = 0; i < DW - 1; i++) step(1, 1, 0, 0, 0, en_lvl, 0);
        step(1, 0, 1, 0, 0, en_lvl, 0);
        idle(1);
        check_eq("flush_full_level", 32'(bus.level), 32'd3);

        // Overflow: nine words, no reads
        do_clear();
        for (int i = 0; i < 9; i++) begin
            words[i] = $urandom();
            send_word(words[i]);
        end
        idle(1);
        check_eq("ovf_level", 32'(bus.level), 32'd8);
        check_eq("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("ovf_order", bus.data_out, words[i]);
            step(0, 0, 0, 0, 1, en_lvl, 0);
        end
        check_eq("ovf_ninth_absent", 32'(bus.valid_out), 32'd0);

        // Full: pop on the cycle the ninth word enters
        do_clear();
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom();
            send_word(words[i]);
        end
        idle(1);
        words[8] = $urandom();
        send_word(words[8]);
        step(0, 0, 0, 0, 1, en_lvl, 0);
        check_eq("full_pp_level", 32'(bus.level), 32'd8);
        check_eq("full_pp_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, en_lvl, 0);
        check_eq("full_pp_last", bus.data_out, words[8]);

        // Interrupt
        en_lvl = 1'b1;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            send_word($urandom());
            idle(1);
            if (i == 2) check_eq("irq_below", 32'(bus.rx_irq), 32'd0);
        end
        check_eq("irq_at_thresh", 32'(bus.rx_irq), 32'd1);
        step(0, 0, 0, 0, 1, en_lvl, 1);
        check_eq("irq_cleared", 32'(bus.rx_irq), 32'd0);
        send_word($urandom());
        idle(1);
        check_eq("irq_again", 32'(bus.rx_irq), 32'd1);
        step(0, 0, 0, 0, 1, en_lvl, 1);
        send_word($urandom());
        step(0, 0, 0, 0, 0, en_lvl, 1);
        check_eq("irq_set_wins", 32'(bus.rx_irq), 32'd1);
        // Enable rising while already above threshold
        en_lvl = 1'b0;
        step(0, 0, 0, 0, 0, en_lvl, 1);
        check_eq("irq_en_low", 32'(bus.rx_irq), 32'd0);
        en_lvl = 1'b1;
        idle(1);
        check_eq("irq_en_rise", 32'(bus.rx_irq), 32'd1);

        // Soft clear with concurrent rd_en and bit_valid
        do_clear();
        for (int i = 0; i < 3; i++) send_word($urandom());
        idle(1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, en_lvl, 0);
        step(1, 1, 0, 1, 1, en_lvl, 0);
        check_eq("clr_level", 32'(bus.level), 32'd0);
        check_eq("clr_valid", 32'(bus.valid_out), 32'd0);
        w = $urandom();
        send_word(w);
        idle(1);
        check_eq("clr_clean_word", bus.data_out, w);

        // Asynchronous reset mid-word
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, en_lvl, 0);
        reset = 1'b0;
        #2;
        check_eq("arst_level", 32'(bus.level), 32'd0);
        check_eq("arst_data", bus.data_out, 32'd0);
        check_eq("arst_irq", 32'(bus.rx_irq), 32'd0);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        w = $urandom();
        send_word(w);
        idle(1);
        check_eq("arst_clean_word", bus.data_out, w);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) en_lvl = ~en_lvl;
            step($urandom_range(0, 9) < 7, 1'($urandom()), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 149) == 0, $urandom_range(0, 9) < 3, en_lvl,
                 $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
